// File: rtl/step_period_meter.sv
// Measures the period of an asynchronous step signal in clock cycles
// and reports the equivalent clock-divider value.
module step_period_meter #(
    parameter int unsigned      WIDTH       = 28,
    parameter logic [WIDTH-1:0] TIMEOUT_CYC = 28'd48_000_000
) (
    input  logic             n_CLK,
    input  logic             n_RST,
    input  logic             i_SIG,
    input  logic             i_EN,
    output logic [WIDTH-1:0] o_PERIOD,
    output logic [WIDTH-1:0] o_DIVIDER,
    output logic             o_VALID,
    output logic             o_TIMEOUT,
    output logic             o_BUSY
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_MEAS  = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             sync1_q, sync2_q, sync3_q;
    logic             rise;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;
    logic             busy_q, busy_d;

    assign rise = sync2_q & ~sync3_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        div_d    = div_q;
        valid_d  = 1'b0;
        tmo_d    = tmo_q;
        if (!i_EN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end
                S_ARMED: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = S_MEAS;
                        cnt_d   = ONE;
                    end
                end
                S_MEAS: begin
                    // A rise on the timeout cycle is still a valid period
                    if (rise) begin
                        period_d = cnt_q;
                        div_d    = (cnt_q >> 1) - ONE;
                        valid_d  = 1'b1;
                        tmo_d    = 1'b0;
                        cnt_d    = ONE;
                    end else if (cnt_q == TIMEOUT_CYC) begin
                        tmo_d   = 1'b1;
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == S_ARMED) || (state_d == S_MEAS);
    end

    always_ff @(posedge n_CLK or negedge n_RST) begin
        if (!n_RST) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            div_q    <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= i_SIG;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            div_q    <= div_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
        end
    end

    assign o_PERIOD  = period_q;
    assign o_DIVIDER = div_q;
    assign o_VALID   = valid_q;
    assign o_TIMEOUT = tmo_q;
    assign o_BUSY    = busy_q;

endmodule

// File: tb/tb_step_period_meter.sv
// Randomised bench for step_period_meter against an edge-timestamp
// reference model, plus directed literal checks.
module tb_step_period_meter;

    localparam int W = 28;
    localparam int T = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sig = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] o_period, o_divider;
    logic         o_valid, o_timeout, o_busy;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    // Reference model: timestamps of detected rises
    int           m_mode = 0;
    longint       m_n = 0;
    longint       m_last = 0;
    logic [W-1:0] m_period = '0;
    logic [W-1:0] m_div = '0;
    logic         m_valid = 1'b0;
    logic         m_tmo = 1'b0;
    bit           hist[$] = '{0, 0, 0, 0};

    step_period_meter #(
        .WIDTH(W),
        .TIMEOUT_CYC(28'd100)
    ) dut (
        .n_CLK(clk),
        .n_RST(rst_n),
        .i_SIG(sig),
        .i_EN(en),
        .o_PERIOD(o_period),
        .o_DIVIDER(o_divider),
        .o_VALID(o_valid),
        .o_TIMEOUT(o_timeout),
        .o_BUSY(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_n = 0; m_last = 0;
            m_period = '0; m_div = '0; m_valid = 0; m_tmo = 0;
            hist = '{0, 0, 0, 0};
        end else begin
            bit     r;
            longint el;
            hist.push_front(sig);
            void'(hist.pop_back());
            // rise on the input is seen two sampling edges later
            r = hist[2] && !hist[3];
            m_n++;
            el = m_n - m_last;
            m_valid = 0;
            if (!en) begin
                m_mode = 0;
                m_tmo = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (r) begin
                    m_mode = 2;
                    m_last = m_n;
                end
            end else begin
                if (r) begin
                    m_period = W'(el);
                    m_div = W'(el / 2 - 1);
                    m_valid = 1;
                    m_tmo = 0;
                    m_last = m_n;
                end else if (el == T) begin
                    m_tmo = 1;
                    m_mode = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("period", o_period, m_period);
        chk("divider", o_divider, m_div);
        chk("valid", o_valid, m_valid);
        chk("timeout", o_timeout, m_tmo);
        chk("busy", o_busy, m_mode != 0);
        if (o_valid) vcount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig = 1'b1;
            repeat (hi) tick();
            sig = 1'b0;
            repeat (lo) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_period", o_period, 0);
        chk("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        vcount = 0;
        wave(5, 5, 6);
        repeat (3) tick();
        chk("div4_vcount", vcount, 5);
        chk("div4_period", o_period, 10);
        chk("div4_divider", o_divider, 4);
        chk("div4_model", m_period, 10);

        wave(3, 4, 5);
        chk("odd_period", o_period, 7);
        chk("odd_divider", o_divider, 2);
        chk("odd_model", m_div, 2);

        wave(1, 1, 6);
        chk("min_period", o_period, 2);
        chk("min_divider", o_divider, 0);

        repeat (150) tick();
        chk("tmo_flag", o_timeout, 1);
        chk("tmo_hold", o_period, 2);
        chk("tmo_model", m_tmo, 1);
        vcount = 0;
        wave(10, 10, 2);
        chk("rec_vcount", vcount, 1);
        chk("rec_period", o_period, 20);
        chk("rec_tmo", o_timeout, 0);

        wave(50, 50, 2);
        chk("coin_period", o_period, 100);
        chk("coin_divider", o_divider, 49);
        chk("coin_tmo", o_timeout, 0);
        chk("coin_model", m_period, 100);

        repeat (110) tick();
        wave(5, 5, 1);
        chk("pre_drop_tmo", o_timeout, 1);
        chk("pre_drop_busy", o_busy, 1);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_busy", o_busy, 0);
        chk("drop_tmo", o_timeout, 0);
        chk("drop_hold", o_period, 100);
        repeat (4) tick();
        en = 1'b1;
        vcount = 0;
        wave(4, 4, 4);
        repeat (3) tick();
        chk("reen_vcount", vcount, 3);
        chk("reen_period", o_period, 8);

        wave(3, 3, 3);
        #2 rst_n = 1'b0;
        sig = 1'b0;
        #1;
        chk("arst_period", o_period, 0);
        chk("arst_divider", o_divider, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_valid", o_valid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        vcount = 0;
        wave(6, 6, 1);
        chk("post_rst_first", vcount, 0);
        wave(6, 6, 2);
        chk("post_rst_vcount", vcount, 2);
        chk("post_rst_period", o_period, 12);

        for (int k = 0; k < 300; k++) begin
            int hi, lo;
            hi = int'($urandom_range(1, 25));
            lo = int'($urandom_range(1, 25));
            if ($urandom_range(0, 9) == 0) lo = int'($urandom_range(90, 130));
            if ($urandom_range(0, 19) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 6)) tick();
                en = 1'b1;
            end
            wave(hi, lo, 1);
        end
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
